// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: chooses the PC load value and drives the imem fetch handshake.
// Latency: decisions are combinational from state and inputs; the PC loads at the next edge.
// Backpressure: stall parks the fetcher in HOLD; an ack without a redirect is the only way forward from FETCH.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_current,
    output logic        pc_write,
    output logic [31:0] pc_next,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        flush,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pending_target;
    logic [31:0] pending_nxt;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending_target;
        pc_write    = 1'b0;
        pc_next     = 32'h0;
        imem_req    = 1'b0;
        flush       = 1'b0;
        if_valid    = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    pc_write  = 1'b1;
                    pc_next   = RESET_VECTOR;
                    state_nxt = FETCH;
                end
                FETCH: begin
                    imem_req = 1'b1;
                    if (redirect_valid) begin
                        flush = 1'b1;
                        if (imem_ack) begin
                            pc_write = 1'b1;
                            pc_next  = redirect_target;
                        end else begin
                            pending_nxt = redirect_target;
                            state_nxt   = DRAIN;
                        end
                    end else if (imem_ack) begin
                        if (stall) begin
                            // Word is dropped here and fetched again once the stall clears.
                            state_nxt = HOLD;
                        end else begin
                            if_valid = 1'b1;
                            pc_write = 1'b1;
                            pc_next  = pc_current + PC_STEP;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc_write  = 1'b1;
                        pc_next   = redirect_target;
                        flush     = 1'b1;
                        state_nxt = FETCH;
                    end else if (!stall) begin
                        state_nxt = FETCH;
                    end
                end
                DRAIN: begin
                    imem_req = 1'b1;
                    if (redirect_valid) begin
                        flush       = 1'b1;
                        pending_nxt = redirect_target;
                    end
                    if (imem_ack) begin
                        pc_write  = 1'b1;
                        pc_next   = redirect_valid ? redirect_target : pending_target;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            pending_target <= 32'h0;
        end else begin
            state          <= state_nxt;
            pending_target <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step queues its expected outputs, then pops and compares them mid-cycle.
module tb_pc_sequencer;

    typedef struct packed {
        logic        pw;
        logic [31:0] nx;
        logic        req;
        logic        fl;
        logic        iv;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_current = 32'h0;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        flush;
    logic        if_valid;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    string tag_q[$];

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .PC_STEP      (32'd4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_current      (pc_current),
        .pc_write        (pc_write),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_ack        (imem_ack),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .flush           (flush),
        .if_valid        (if_valid)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic pw, input logic [31:0] nx, input logic req,
                                input logic fl, input logic iv);
        exp_t e;
        e.pw  = pw;
        e.nx  = nx;
        e.req = req;
        e.fl  = fl;
        e.iv  = iv;
        return e;
    endfunction

    task automatic step(input logic r, input logic [31:0] pc, input logic ack, input logic st,
                        input logic rv, input logic [31:0] rt, input exp_t e, input string tag);
        exp_t  want;
        exp_t  got;
        string t;
        reset           = r;
        pc_current      = pc;
        imem_ack        = ack;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        got  = mk(pc_write, pc_next, imem_req, flush, if_valid);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed pw=%b nx=%h req=%b fl=%b iv=%b expected pw=%b nx=%h req=%b fl=%b iv=%b",
                   t, got.pw, got.nx, got.req, got.fl, got.iv,
                   want.pw, want.nx, want.req, want.fl, want.iv);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        // reset with ack high: everything quiet
        step(1, 32'h0, 1, 0, 0, 32'h0, mk(0, 32'h0, 0, 0, 0), "reset_outputs");
        // IDLE ignores stall, loads reset vector
        step(0, 32'h0, 1, 1, 0, 32'h0, mk(1, 32'h0, 0, 0, 0), "idle_load");
        // zero-wait stream
        step(0, 32'h0, 1, 0, 0, 32'h0, mk(1, 32'h4, 1, 0, 1), "zw_0");
        step(0, 32'h4, 1, 0, 0, 32'h0, mk(1, 32'h8, 1, 0, 1), "zw_4");
        step(0, 32'h8, 1, 0, 0, 32'h0, mk(1, 32'hC, 1, 0, 1), "zw_8");
        // 2-wait-state fetch at 0x10
        step(0, 32'h10, 0, 0, 0, 32'h0, mk(0, 32'h0, 1, 0, 0), "ws_wait1");
        step(0, 32'h10, 0, 0, 0, 32'h0, mk(0, 32'h0, 1, 0, 0), "ws_wait2");
        step(0, 32'h10, 1, 0, 0, 32'h0, mk(1, 32'h14, 1, 0, 1), "ws_ack");
        // redirect 0x200 with fetch outstanding
        step(0, 32'h14, 0, 0, 1, 32'h200, mk(0, 32'h0, 1, 1, 0), "drain_enter");
        step(0, 32'h14, 0, 0, 0, 32'h0, mk(0, 32'h0, 1, 0, 0), "drain_wait");
        step(0, 32'h14, 1, 0, 0, 32'h0, mk(1, 32'h200, 1, 0, 0), "drain_ack");
        // two redirects while draining, newest wins
        step(0, 32'h200, 0, 0, 1, 32'h100, mk(0, 32'h0, 1, 1, 0), "dd_first");
        step(0, 32'h200, 0, 0, 1, 32'h300, mk(0, 32'h0, 1, 1, 0), "dd_second");
        step(0, 32'h200, 0, 0, 0, 32'h0, mk(0, 32'h0, 1, 0, 0), "dd_wait");
        step(0, 32'h200, 1, 0, 0, 32'h0, mk(1, 32'h300, 1, 0, 0), "dd_ack");
        // redirect on an ack cycle
        step(0, 32'h300, 1, 0, 1, 32'h40, mk(1, 32'h40, 1, 1, 0), "redir_ack");
        // stall on ack at 0x40 for three cycles
        step(0, 32'h40, 1, 1, 0, 32'h0, mk(0, 32'h0, 1, 0, 0), "stall_ack");
        step(0, 32'h40, 1, 1, 0, 32'h0, mk(0, 32'h0, 0, 0, 0), "hold_1");
        step(0, 32'h40, 1, 1, 0, 32'h0, mk(0, 32'h0, 0, 0, 0), "hold_2");
        step(0, 32'h40, 1, 0, 0, 32'h0, mk(0, 32'h0, 0, 0, 0), "hold_release");
        step(0, 32'h40, 1, 0, 0, 32'h0, mk(1, 32'h44, 1, 0, 1), "refetch_40");
        // redirect during HOLD overrides stall
        step(0, 32'h44, 1, 1, 0, 32'h0, mk(0, 32'h0, 1, 0, 0), "stall_ack2");
        step(0, 32'h44, 0, 1, 1, 32'h80, mk(1, 32'h80, 0, 1, 0), "hold_redir");
        step(0, 32'h80, 1, 0, 0, 32'h0, mk(1, 32'h84, 1, 0, 1), "fetch_80");
        // PC wrap
        step(0, 32'hFFFF_FFFC, 1, 0, 0, 32'h0, mk(1, 32'h0, 1, 0, 1), "pc_wrap");
        // redirect coinciding with the drain ack
        step(0, 32'h0, 0, 0, 1, 32'h500, mk(0, 32'h0, 1, 1, 0), "dr2_enter");
        step(0, 32'h0, 1, 0, 1, 32'h600, mk(1, 32'h600, 1, 1, 0), "dr2_ack_redir");
        // reset mid-drain, restart from reset vector
        step(0, 32'h600, 0, 0, 1, 32'h700, mk(0, 32'h0, 1, 1, 0), "dr3_enter");
        step(1, 32'h600, 1, 0, 1, 32'h700, mk(0, 32'h0, 0, 0, 0), "reset_mid_drain");
        step(0, 32'h600, 1, 0, 1, 32'h900, mk(1, 32'h0, 0, 0, 0), "idle_after_reset");
        step(0, 32'h0, 1, 0, 0, 32'h0, mk(1, 32'h4, 1, 0, 1), "restart_fetch");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
